// File: rtl/contagem_pkg.sv
// Shared types and constants for the count bus observer: classification codes,
// the observer FSM state, and the default bus/step sizes.
package contagem_pkg;
  localparam int NBITS_CONTAGEM = 4;
  localparam int STEP_SMALL     = 1;
  localparam int STEP_LARGE     = 3;
  localparam int NBITS_ERR      = 8;
  localparam int STABLE_N       = 4;

  typedef enum logic [3:0] {
    M_NONE   = 4'd0,
    M_UP1    = 4'd1,
    M_UP3    = 4'd2,
    M_DN1    = 4'd3,
    M_DN3    = 4'd4,
    M_FREEZE = 4'd5,
    M_SAT    = 4'd6,
    M_RESET  = 4'd7,
    M_ERR    = 4'd8
  } mode_t;

  typedef enum logic {EMPTY, PRIMED} state_t;

  function automatic logic is_up(input mode_t m);
    return (m == M_UP1) || (m == M_UP3);
  endfunction

  function automatic logic is_dn(input mode_t m);
    return (m == M_DN1) || (m == M_DN3);
  endfunction
endpackage

// File: rtl/count_step_decoder_step_classifier.sv
// Pure combinational decision of which counter operation turned prev into cur,
// plus whether that move crossed the max<->0 boundary.
module step_classifier
  import contagem_pkg::*;
#(
  parameter int N  = NBITS_CONTAGEM,
  parameter int SS = STEP_SMALL,
  parameter int SL = STEP_LARGE
) (
  input  logic [N-1:0] prev,
  input  logic [N-1:0] cur,
  output mode_t        mode,
  output logic         wrap
);
  localparam logic [N-1:0] D_UP1 = N'(SS);
  localparam logic [N-1:0] D_UP3 = N'(SL);
  localparam logic [N-1:0] D_DN1 = N'((1 << N) - SS);
  localparam logic [N-1:0] D_DN3 = N'((1 << N) - SL);

  logic [N-1:0] d;

  // Step classes are tested before the jump-to-zero case so 15->0 reads as UP1.
  always_comb begin
    d    = cur - prev;
    mode = M_ERR;
    if (d == '0)
      mode = ((prev == '0) || (prev == '1)) ? M_SAT : M_FREEZE;
    else if (d == D_UP1) mode = M_UP1;
    else if (d == D_UP3) mode = M_UP3;
    else if (d == D_DN1) mode = M_DN1;
    else if (d == D_DN3) mode = M_DN3;
    else if (cur == '0)  mode = M_RESET;
    wrap = (is_up(mode) && (cur < prev)) || (is_dn(mode) && (cur > prev));
  end
endmodule

// File: rtl/count_step_decoder.sv
// Observes the counter's count bus and reports, per accepted sample, which
// operation the counter performed, with direction/stability/error status.
module count_step_decoder
  import contagem_pkg::*;
#(
  parameter int NBITS_CONTAGEM = contagem_pkg::NBITS_CONTAGEM,
  parameter int STEP_SMALL     = contagem_pkg::STEP_SMALL,
  parameter int STEP_LARGE     = contagem_pkg::STEP_LARGE,
  parameter int NBITS_ERR      = contagem_pkg::NBITS_ERR,
  parameter int STABLE_N       = contagem_pkg::STABLE_N
) (
  input  logic                      clk_2,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [NBITS_CONTAGEM-1:0] count_in,
  output logic [3:0]                mode_out,
  output logic                      mode_valid,
  output logic                      dir_down,
  output logic                      step_large,
  output logic                      wrapped,
  output logic                      stable,
  output logic [NBITS_ERR-1:0]      err_count,
  output logic [NBITS_CONTAGEM-1:0] last_count
);
  localparam int RW = $clog2(STABLE_N + 1);

  state_t        state, state_nxt;
  mode_t         mode_q, cls;
  logic          cls_wrap;
  logic [RW-1:0] run;

  step_classifier #(
    .N  (NBITS_CONTAGEM),
    .SS (STEP_SMALL),
    .SL (STEP_LARGE)
  ) u_cls (
    .prev (last_count),
    .cur  (count_in),
    .mode (cls),
    .wrap (cls_wrap)
  );

  always_ff @(posedge clk_2) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // EMPTY only ever waits for the first sample; nothing leads back to it but reset.
  always_comb begin
    state_nxt = state;
    if (state == EMPTY && valid_in) state_nxt = PRIMED;
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      mode_q     <= M_NONE;
      mode_valid <= 1'b0;
      dir_down   <= 1'b0;
      step_large <= 1'b0;
      wrapped    <= 1'b0;
      err_count  <= '0;
      last_count <= '0;
      run        <= '0;
    end else begin
      mode_valid <= 1'b0;
      wrapped    <= 1'b0;
      if (valid_in) begin
        last_count <= count_in;
        if (state == PRIMED) begin
          mode_q     <= cls;
          mode_valid <= 1'b1;
          wrapped    <= cls_wrap;
          if (is_up(cls) || is_dn(cls)) begin
            dir_down   <= is_dn(cls);
            step_large <= (cls == M_UP3) || (cls == M_DN3);
          end else if (cls == M_RESET) begin
            dir_down   <= 1'b0;
            step_large <= 1'b0;
          end
          if (cls == M_ERR) begin
            run <= '0;
            if (err_count != '1) err_count <= err_count + 1'b1;
          end else if (cls == mode_q) begin
            if (run < RW'(STABLE_N)) run <= run + 1'b1;
          end else begin
            run <= RW'(1);
          end
        end
      end
    end
  end

  assign mode_out = mode_q;
  assign stable   = (run >= RW'(STABLE_N));
endmodule

// File: tb/tb_count_step_decoder.sv
// Randomized + directed bench: a driver feeds samples and queues the expected
// outputs from a history-based reference model; a monitor checks every cycle.
module tb_count_step_decoder;
  import contagem_pkg::*;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [3:0] count_in = '0;
  logic [3:0] mode_out;
  logic       mode_valid, dir_down, step_large, wrapped, stable;
  logic [7:0] err_count;
  logic [3:0] last_count;

  count_step_decoder dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .valid_in   (valid_in),
    .count_in   (count_in),
    .mode_out   (mode_out),
    .mode_valid (mode_valid),
    .dir_down   (dir_down),
    .step_large (step_large),
    .wrapped    (wrapped),
    .stable     (stable),
    .err_count  (err_count),
    .last_count (last_count)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    int mode; bit mv; bit dd; bit sl; bit wr; bit st; int errs; int last;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state: everything seen since the last reset
  bit   have_prev = 0;
  int   prev = 0;
  int   hist[$];
  exp_t m;

  function automatic int classify(input int p, input int c);
    int d = (c - p + 16) % 16;
    if (d == 0)  return (p == 0 || p == 15) ? int'(M_SAT) : int'(M_FREEZE);
    if (d == 1)  return int'(M_UP1);
    if (d == 3)  return int'(M_UP3);
    if (d == 15) return int'(M_DN1);
    if (d == 13) return int'(M_DN3);
    if (c == 0)  return int'(M_RESET);
    return int'(M_ERR);
  endfunction

  function automatic bit hist_stable();
    int n = hist.size();
    if (n < 4) return 0;
    for (int i = n - 4; i < n; i++)
      if (hist[i] != hist[n-1]) return 0;
    return hist[n-1] != int'(M_ERR);
  endfunction

  task automatic apply(input bit r, input bit v, input int c);
    int  k;
    bit  up, dn;
    @(negedge clk_2);
    reset = r; valid_in = v; count_in = 4'(c);
    m.mv = 0; m.wr = 0;
    if (r) begin
      have_prev = 0; prev = 0; hist.delete();
      m = '{mode: int'(M_NONE), mv: 0, dd: 0, sl: 0, wr: 0, st: 0, errs: 0, last: 0};
    end else if (v) begin
      if (have_prev) begin
        k  = classify(prev, c);
        up = (k == int'(M_UP1) || k == int'(M_UP3));
        dn = (k == int'(M_DN1) || k == int'(M_DN3));
        m.mode = k; m.mv = 1;
        m.wr = (up && c < prev) || (dn && c > prev);
        if (up || dn) begin
          m.dd = dn;
          m.sl = (k == int'(M_UP3) || k == int'(M_DN3));
        end else if (k == int'(M_RESET)) begin
          m.dd = 0; m.sl = 0;
        end
        if (k == int'(M_ERR) && m.errs < 255) m.errs++;
        hist.push_back(k);
        if (hist.size() > 8) void'(hist.pop_front());
      end
      have_prev = 1; prev = c; m.last = c;
    end
    m.st = hist_stable();
    sb.push_back(m);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // monitor: one expected record per driven cycle, checked just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_2);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        chk("mode_out",   int'(mode_out),   e.mode);
        chk("mode_valid", int'(mode_valid), int'(e.mv));
        chk("dir_down",   int'(dir_down),   int'(e.dd));
        chk("step_large", int'(step_large), int'(e.sl));
        chk("wrapped",    int'(wrapped),    int'(e.wr));
        chk("stable",     int'(stable),     int'(e.st));
        chk("err_count",  int'(err_count),  e.errs);
        chk("last_count", int'(last_count), e.last);
      end
    end
  end

  initial begin
    int seq1[] = '{2, 3, 4, 5, 6, 14, 1, 14, 15, 15, 7, 7, 9, 0, 1, 0};
    int c;
    m = '{mode: 0, mv: 0, dd: 0, sl: 0, wr: 0, st: 0, errs: 0, last: 0};
    apply(1, 0, 0);
    apply(1, 0, 0);
    foreach (seq1[i]) apply(0, 1, seq1[i]);
    // gaps must keep last_count and produce no pulses
    apply(0, 0, 9);
    apply(0, 0, 12);
    apply(0, 1, 1);
    // reset between samples 5 and 6: the 6 only re-primes
    apply(1, 0, 0);
    for (int s = 2; s <= 5; s++) apply(0, 1, s);
    apply(1, 0, 0);
    apply(0, 1, 6);
    apply(0, 1, 7);
    // alternating illegal jumps drive the tally into saturation
    for (int i = 0; i < 300; i++) begin
      apply(0, 1, 4);
      apply(0, 1, 9);
    end
    apply(0, 1, 10);
    // random traffic biased toward legal steps
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0:       c = prev + 1;
        1:       c = prev + 3;
        2:       c = prev - 1;
        3:       c = prev - 3;
        4:       c = prev;
        5:       c = 0;
        default: c = $urandom_range(0, 15);
      endcase
      c = (c + 16) % 16;
      apply($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, c);
    end
    apply(0, 0, 0);
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk_2);
    #2;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d records left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
